uart_cmd_decoder: RTL

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_pkg.sv | 36 +++
 rtl/uart_word_serializer.sv | 97 +++++++++
 rtl/uart_cmd_decoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder.
// Holds the opcode values, the field widths and the state encodings used by
// the command parser (uart_cmd_decoder) and the read-data return path
// (uart_word_serializer).
`timescale 1ns/1ps

package uart_cmd_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = WORD_W / BYTE_W;

    // The byte counter is 2 bits wide, so a field completes when it reads 3.
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    localparam logic [BYTE_W-1:0] OPC_WRITE = 8'h57;  // 'W'
    localparam logic [BYTE_W-1:0] OPC_READ  = 8'h52;  // 'R'

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ISSUE
    } parse_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_SEND
    } ret_state_t;

    function automatic logic is_opcode(input logic [BYTE_W-1:0] b);
        return (b == OPC_WRITE) || (b == OPC_READ);
    endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// Read-data return path: pops one 32-bit word from the AXI master RX FIFO and
// sends it to the UART transmitter as four bytes, MSB first, over a
// valid/ready handshake.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   RX_FIFO_DATA_IN     read data from the RX FIFO
//   RX_FIFO_RD_EN       one-cycle pop strobe
//   RX_FIFO_EMPTY       RX FIFO empty flag
//   RX_FIFO_DATA_VALID  RX_FIFO_DATA_IN valid this cycle
//   TX_BYTE_OUT         byte to the UART transmitter
//   TX_BYTE_VALID       TX_BYTE_OUT valid, held until accepted
//   TX_BYTE_READY       transmitter accepts the byte
`timescale 1ns/1ps

module uart_word_serializer
    import uart_cmd_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [C_DATA_WIDTH-1:0] RX_FIFO_DATA_IN,
    output logic                    RX_FIFO_RD_EN,
    input  logic                    RX_FIFO_EMPTY,
    input  logic                    RX_FIFO_DATA_VALID,
    output logic [BYTE_W-1:0]       TX_BYTE_OUT,
    output logic                    TX_BYTE_VALID,
    input  logic                    TX_BYTE_READY
);

    ret_state_t              r_state;
    logic [1:0]              r_byte_cnt;
    logic [C_DATA_WIDTH-1:0] r_word;
    logic                    r_rd_en;
    logic                    r_tx_valid;

    // The outgoing byte is always the top of the shift register, so a drained
    // word leaves TX_BYTE_OUT at zero.
    assign TX_BYTE_OUT   = r_word[C_DATA_WIDTH-1 -: BYTE_W];
    assign TX_BYTE_VALID = r_tx_valid;
    assign RX_FIFO_RD_EN = r_rd_en;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other register.
    always_ff @(posedge ACLK) begin
        // NOTE: reset is synchronous and clears the datapath as well as the
        // control state, because the byte output is observable after reset.
        if (ARESET) begin
            r_state    <= R_IDLE;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_rd_en    <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    r_byte_cnt <= '0;
                    if (!RX_FIFO_EMPTY) begin
                        r_rd_en <= 1'b1;
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    r_rd_en <= 1'b0;
                    if (RX_FIFO_DATA_VALID) begin
                        r_word     <= RX_FIFO_DATA_IN;
                        r_tx_valid <= 1'b1;
                        r_byte_cnt <= '0;
                        r_state    <= R_SEND;
                    end
                end
                R_SEND: begin
                    // A byte moves only on the cycle both valid and ready
                    // are high; the next byte appears on the following cycle.
                    if (TX_BYTE_READY) begin
                        r_word <= {r_word[C_DATA_WIDTH-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_tx_valid <= 1'b0;
                            r_byte_cnt <= '0;
                            r_state    <= R_IDLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    r_rd_en    <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_byte_cnt <= '0;
                    r_state    <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder. Parses write packets (0x57, addr[4], data[4]) and
// read packets (0x52, addr[4]) arriving one byte per RX_BYTE_VALID strobe,
// pushes them to the AXI master TX FIFO or read-request FIFO, and returns
// read data through uart_word_serializer.
//
// Ports
//   ACLK, ARESET         clock, synchronous active-high reset
//   RX_BYTE_IN/VALID     received byte and its one-cycle strobe
//   TX_FIFO_*            write address/data push to the AXI master TX FIFO
//   REQ_ADDR_FIFO_*      read address push to the request FIFO
//   RX_FIFO_*            read data pop from the AXI master RX FIFO
//   TX_BYTE_*            byte stream to the UART transmitter
//   CMD_ERROR            one-cycle strobe on any protocol error
`timescale 1ns/1ps

module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_DATA_WIDTH     = 32,
    parameter int C_TIMEOUT_CYCLES = 100000
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [BYTE_W-1:0]       RX_BYTE_IN,
    input  logic                    RX_BYTE_VALID,
    output logic [C_ADDR_WIDTH-1:0] TX_FIFO_ADDR_OUT,
    output logic [C_DATA_WIDTH-1:0] TX_FIFO_DATA_OUT,
    output logic                    TX_FIFO_WR_EN,
    input  logic                    TX_FIFO_FULL,
    output logic [C_ADDR_WIDTH-1:0] REQ_ADDR_FIFO_OUT,
    output logic                    REQ_ADDR_FIFO_WR_EN,
    input  logic                    REQ_ADDR_FIFO_FULL,
    input  logic [C_DATA_WIDTH-1:0] RX_FIFO_DATA_IN,
    output logic                    RX_FIFO_RD_EN,
    input  logic                    RX_FIFO_EMPTY,
    input  logic                    RX_FIFO_DATA_VALID,
    output logic [BYTE_W-1:0]       TX_BYTE_OUT,
    output logic                    TX_BYTE_VALID,
    input  logic                    TX_BYTE_READY,
    output logic                    CMD_ERROR
);

    // Counts 0 .. C_TIMEOUT_CYCLES-1 idle cycles inside a packet.
    localparam int TO_W = $clog2(C_TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(C_TIMEOUT_CYCLES - 1);

    parse_state_t            r_state;
    logic [1:0]              r_byte_cnt;
    logic [TO_W-1:0]         r_to_cnt;
    logic                    r_is_write;
    logic [C_ADDR_WIDTH-1:0] r_addr;
    logic [C_DATA_WIDTH-1:0] r_data;
    logic                    r_tx_wr_en;
    logic                    r_req_wr_en;
    logic                    r_cmd_error;

    assign TX_FIFO_ADDR_OUT    = r_addr;
    assign TX_FIFO_DATA_OUT    = r_data;
    assign TX_FIFO_WR_EN       = r_tx_wr_en;
    assign REQ_ADDR_FIFO_OUT   = r_addr;
    assign REQ_ADDR_FIFO_WR_EN = r_req_wr_en;
    assign CMD_ERROR           = r_cmd_error;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_byte_cnt  <= '0;
            r_to_cnt    <= '0;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_tx_wr_en  <= 1'b0;
            r_req_wr_en <= 1'b0;
            r_cmd_error <= 1'b0;
        end else begin
            // NOTE: the error strobe defaults low every cycle; any number of
            // error causes in one cycle collapse into a single pulse.
            r_cmd_error <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_byte_cnt <= '0;
                    r_to_cnt   <= '0;
                    if (RX_BYTE_VALID) begin
                        if (is_opcode(RX_BYTE_IN)) begin
                            r_is_write <= (RX_BYTE_IN == OPC_WRITE);
                            r_state    <= ADDR;
                        end else begin
                            r_cmd_error <= 1'b1;
                        end
                    end
                end

                ADDR, DATA: begin
                    if (RX_BYTE_VALID) begin
                        r_to_cnt <= '0;
                        if (r_state == ADDR) begin
                            r_addr <= {r_addr[C_ADDR_WIDTH-BYTE_W-1:0], RX_BYTE_IN};
                        end else begin
                            r_data <= {r_data[C_DATA_WIDTH-BYTE_W-1:0], RX_BYTE_IN};
                        end
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            if (r_state == ADDR && r_is_write) begin
                                r_state <= DATA;
                            end else begin
                                // Push straight away when the target FIFO has
                                // room, so WR_EN lands on the cycle after the
                                // final byte; otherwise ISSUE retries.
                                r_state     <= ISSUE;
                                r_tx_wr_en  <= r_is_write  && !TX_FIFO_FULL;
                                r_req_wr_en <= !r_is_write && !REQ_ADDR_FIFO_FULL;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        // Line went quiet mid-packet: drop it and resync.
                        r_cmd_error <= 1'b1;
                        r_byte_cnt  <= '0;
                        r_to_cnt    <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                ISSUE: begin
                    // Bytes arriving while a packet waits are dropped.
                    if (RX_BYTE_VALID) begin
                        r_cmd_error <= 1'b1;
                    end
                    if (r_tx_wr_en || r_req_wr_en) begin
                        r_tx_wr_en  <= 1'b0;
                        r_req_wr_en <= 1'b0;
                        r_byte_cnt  <= '0;
                        r_state     <= IDLE;
                    end else if (r_is_write) begin
                        r_tx_wr_en <= !TX_FIFO_FULL;
                    end else begin
                        r_req_wr_en <= !REQ_ADDR_FIFO_FULL;
                    end
                end

                default: begin
                    r_tx_wr_en  <= 1'b0;
                    r_req_wr_en <= 1'b0;
                    r_byte_cnt  <= '0;
                    r_to_cnt    <= '0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    uart_word_serializer #(
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_word_serializer (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .RX_FIFO_DATA_IN    (RX_FIFO_DATA_IN),
        .RX_FIFO_RD_EN      (RX_FIFO_RD_EN),
        .RX_FIFO_EMPTY      (RX_FIFO_EMPTY),
        .RX_FIFO_DATA_VALID (RX_FIFO_DATA_VALID),
        .TX_BYTE_OUT        (TX_BYTE_OUT),
        .TX_BYTE_VALID      (TX_BYTE_VALID),
        .TX_BYTE_READY      (TX_BYTE_READY)
    );

endmodule
